// File: rtl/cond_unit.sv
// Condition unit: owns the NZCV flags, evaluates each instruction's condition at
// decode, latches the execute decision and gates the control FSM's write enables.
module cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pc_w_req,
  input  logic             pc_update,
  input  logic             reg_w_req,
  input  logic             mem_w_req,
  input  logic             no_write,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic [3:0]       flags,
  output logic             cond_ex_q,
  output logic             cond_undef,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  logic [3:0]       r_flags;
  logic             r_cond_ex;
  logic             r_undef;
  logic [CNT_W-1:0] r_exec;
  logic [CNT_W-1:0] r_skip;

  logic             w_nz_we;
  logic             w_cv_we;
  logic [1:0]       w_nz;
  logic [1:0]       w_cv;
  logic             w_ge;
  logic             w_pass;
  logic             w_live;

  assign w_nz_we = flag_w[1] & r_cond_ex;
  assign w_cv_we = flag_w[0] & r_cond_ex;

  // Evaluate on the post-write flags so a same-cycle flag update is seen, per half.
  assign w_nz = w_nz_we ? alu_flags[3:2] : r_flags[3:2];
  assign w_cv = w_cv_we ? alu_flags[1:0] : r_flags[1:0];
  assign w_ge = (w_nz[1] == w_cv[0]);

  always_comb begin
    w_pass = 1'b0;
    case (cond_e'(cond))
      C_EQ:    w_pass =  w_nz[0];
      C_NE:    w_pass = ~w_nz[0];
      C_CS:    w_pass =  w_cv[1];
      C_CC:    w_pass = ~w_cv[1];
      C_MI:    w_pass =  w_nz[1];
      C_PL:    w_pass = ~w_nz[1];
      C_VS:    w_pass =  w_cv[0];
      C_VC:    w_pass = ~w_cv[0];
      C_HI:    w_pass =  (w_cv[1] & ~w_nz[0]);
      C_LS:    w_pass = ~(w_cv[1] & ~w_nz[0]);
      C_GE:    w_pass =  w_ge;
      C_LT:    w_pass = ~w_ge;
      C_GT:    w_pass =  (~w_nz[0] & w_ge);
      C_LE:    w_pass = ~(~w_nz[0] & w_ge);
      C_AL:    w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags   <= '0;
      r_cond_ex <= 1'b0;
      r_undef   <= 1'b0;
      r_exec    <= '0;
      r_skip    <= '0;
    end else begin
      if (w_nz_we) r_flags[3:2] <= alu_flags[3:2];
      if (w_cv_we) r_flags[1:0] <= alu_flags[1:0];
      if (instr_valid) r_cond_ex <= w_pass;
      r_undef <= instr_valid & (cond == 4'hF);
      if (cnt_clr) begin
        r_exec <= '0;
        r_skip <= '0;
      end else if (instr_valid) begin
        if (w_pass) begin
          if (r_exec != '1) r_exec <= r_exec + CNT_W'(1);
        end else begin
          if (r_skip != '1) r_skip <= r_skip + CNT_W'(1);
        end
      end
    end
  end

  // Gating is forced off while reset is asserted, before the register has cleared.
  assign w_live    = r_cond_ex & rst_n;
  assign pc_write  = (pc_w_req & w_live) | pc_update;
  assign reg_write = reg_w_req & w_live & ~no_write;
  assign mem_write = mem_w_req & w_live;

  assign flags      = r_flags;
  assign cond_ex_q  = r_cond_ex;
  assign cond_undef = r_undef;
  assign exec_cnt   = r_exec;
  assign skip_cnt   = r_skip;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with hand-computed expectations; 4-bit counters
// so saturation is reachable quickly.
module tb_cond_unit;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic [3:0]    cond;
  logic [3:0]    alu_flags;
  logic [1:0]    flag_w;
  logic          pc_w_req;
  logic          pc_update;
  logic          reg_w_req;
  logic          mem_w_req;
  logic          no_write;
  logic          cnt_clr;
  logic          pc_write;
  logic          reg_write;
  logic          mem_write;
  logic [3:0]    flags;
  logic          cond_ex_q;
  logic          cond_undef;
  logic [CW-1:0] exec_cnt;
  logic [CW-1:0] skip_cnt;

  int unsigned n_checks;
  int unsigned n_errors;

  cond_unit #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .cond        (cond),
    .alu_flags   (alu_flags),
    .flag_w      (flag_w),
    .pc_w_req    (pc_w_req),
    .pc_update   (pc_update),
    .reg_w_req   (reg_w_req),
    .mem_w_req   (mem_w_req),
    .no_write    (no_write),
    .cnt_clr     (cnt_clr),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .flags       (flags),
    .cond_ex_q   (cond_ex_q),
    .cond_undef  (cond_undef),
    .exec_cnt    (exec_cnt),
    .skip_cnt    (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0; cond = 4'h0; alu_flags = 4'h0; flag_w = 2'b00;
    pc_w_req = 1'b0; pc_update = 1'b0; reg_w_req = 1'b0; mem_w_req = 1'b0;
    no_write = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic issue(input logic [3:0] c);
    instr_valid = 1'b1;
    cond = c;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    issue(4'hE);
    flag_w = 2'b11; alu_flags = f;
    step();
    flag_w = 2'b00; alu_flags = 4'h0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset with every request asserted
    rst_n = 1'b0; instr_valid = 1'b1; cond = 4'hE; alu_flags = 4'hF; flag_w = 2'b11;
    pc_w_req = 1'b1; pc_update = 1'b1; reg_w_req = 1'b1; mem_w_req = 1'b1;
    no_write = 1'b0; cnt_clr = 1'b0;
    step(); step();
    check("rst_flags", flags, 4'h0);
    check("rst_cond_ex", cond_ex_q, 0);
    check("rst_undef", cond_undef, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_pc_write_upd", pc_write, 1);
    check("rst_exec", exec_cnt, 0);
    check("rst_skip", skip_cnt, 0);
    pc_update = 1'b0; #1;
    check("rst_pc_write_noupd", pc_write, 0);
    idle();
    rst_n = 1'b1;

    // Requests before the first decode are suppressed
    reg_w_req = 1'b1; mem_w_req = 1'b1; pc_w_req = 1'b1; flag_w = 2'b11; alu_flags = 4'hF;
    #1;
    check("pre_reg_write", reg_write, 0);
    check("pre_mem_write", mem_write, 0);
    check("pre_pc_write", pc_write, 0);
    step();
    check("pre_flags", flags, 4'h0);
    idle();

    // Flag write then EQ / NE
    issue(4'hE);
    check("al_cond_ex", cond_ex_q, 1);
    flag_w = 2'b11; alu_flags = 4'b0100;
    step();
    flag_w = 2'b00; alu_flags = 4'h0;
    check("fw_flags", flags, 4'b0100);
    issue(4'h0);
    check("eq_cond_ex", cond_ex_q, 1);
    reg_w_req = 1'b1; mem_w_req = 1'b1; pc_w_req = 1'b1; #1;
    check("eq_reg_write", reg_write, 1);
    check("eq_mem_write", mem_write, 1);
    check("eq_pc_write", pc_write, 1);
    mem_w_req = 1'b0; pc_w_req = 1'b0;
    instr_valid = 1'b1; cond = 4'h1; #1;
    check("ne_sameT_reg_write", reg_write, 1);
    step();
    instr_valid = 1'b0;
    check("ne_cond_ex", cond_ex_q, 0);
    check("ne_reg_write", reg_write, 0);
    check("ne_exec", exec_cnt, 2);
    check("ne_skip", skip_cnt, 1);
    reg_w_req = 1'b0;
    flag_w = 2'b11; alu_flags = 4'hF;
    step();
    flag_w = 2'b00; alu_flags = 4'h0;
    check("skipped_fw_flags", flags, 4'b0100);

    // Same-cycle flag bypass, full and per half
    set_flags(4'b0000);
    check("byp_pre_flags", flags, 4'b0000);
    flag_w = 2'b11; alu_flags = 4'b1000;
    issue(4'h4);
    check("byp_mi_cond_ex", cond_ex_q, 1);
    check("byp_flags", flags, 4'b1000);
    flag_w = 2'b01; alu_flags = 4'b0001;
    issue(4'h4);
    flag_w = 2'b00; alu_flags = 4'h0;
    check("byp_half_mi", cond_ex_q, 1);
    check("byp_half_flags", flags, 4'b1001);

    // Signed / unsigned comparisons
    issue(4'hA); check("ge_1001", cond_ex_q, 1);
    issue(4'hC); check("gt_1001", cond_ex_q, 1);
    issue(4'hB); check("lt_1001", cond_ex_q, 0);
    set_flags(4'b1000);
    issue(4'hB); check("lt_1000", cond_ex_q, 1);
    issue(4'hD); check("le_1000", cond_ex_q, 1);
    issue(4'hA); check("ge_1000", cond_ex_q, 0);
    set_flags(4'b0110);
    issue(4'h8); check("hi_0110", cond_ex_q, 0);
    issue(4'h9); check("ls_0110", cond_ex_q, 1);

    // Undefined condition
    issue(4'hF);
    check("undef_pulse", cond_undef, 1);
    check("undef_cond_ex", cond_ex_q, 0);
    check("undef_exec", exec_cnt, 12);
    check("undef_skip", skip_cnt, 5);
    step();
    check("undef_drop", cond_undef, 0);

    // no_write blocks register write but flags still update
    issue(4'hE);
    reg_w_req = 1'b1; no_write = 1'b1; flag_w = 2'b11; alu_flags = 4'b0011; #1;
    check("nowr_reg_write", reg_write, 0);
    step();
    check("nowr_flags", flags, 4'b0011);
    idle();

    // Counter saturation and clear priority
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    check("clr_exec", exec_cnt, 0);
    check("clr_skip", skip_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      issue(4'hE);
      if (i == 9) check("cnt_exec_10", exec_cnt, 10);
    end
    check("sat_exec", exec_cnt, 15);
    issue(4'hF);
    check("sat_exec_hold", exec_cnt, 15);
    check("sat_skip", skip_cnt, 1);
    cnt_clr = 1'b1;
    issue(4'h0);
    cnt_clr = 1'b0;
    check("clrwin_exec", exec_cnt, 0);
    check("clrwin_skip", skip_cnt, 0);
    check("clrwin_cond_ex", cond_ex_q, 0);

    // Reset mid-instruction discards the decision
    issue(4'hE);
    reg_w_req = 1'b1; #1;
    check("mid_reg_write", reg_write, 1);
    rst_n = 1'b0; #1;
    check("mid_rst_comb", reg_write, 0);
    step();
    rst_n = 1'b1; #1;
    check("mid_cond_ex", cond_ex_q, 0);
    check("mid_flags", flags, 4'h0);
    step();
    check("mid_held_req", reg_write, 0);
    issue(4'hE);
    check("mid_new_decode", reg_write, 1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
